// File: rtl/beta_serializer.sv
// -----------------------------------------------------------------------------
// beta_serializer
//
// Purpose: buffers A-element vectors of signed 8-bit beta values in a small
// vector FIFO. It then streams each vector out one element per beat over a
// valid/ready output. Element 0 goes out first, and m_tlast marks element A-1.
//
// Optional feature: when the macro BETA_ARGMAX_EN is defined, the block
// computes the index of the largest signed element of each vector as that
// vector is loaded. Ties resolve to the lowest index. The index is presented
// on m_argmax for every beat of the vector. Without the macro, m_argmax is
// tied to 0.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   beta         input vector, element k at bits [k*8+7:k*8]
//   beta_tvalid  one-cycle write strobe (upstream has no backpressure)
//   m_tdata      serialized element
//   m_tvalid     m_tdata valid (high exactly while the FSM is in SEND)
//   m_tready     downstream accepts the beat
//   m_tlast      high on element A-1 of a vector
//   m_argmax     argmax index of the vector being sent
//   fifo_count   vectors stored in the FIFO and not yet loaded
//   overflow     sticky: a vector arrived while the FIFO was full with no pop
//
// Output handshake: a beat transfers on a rising edge where m_tvalid and
// m_tready are both high. While m_tvalid=1 and m_tready=0, the block holds
// m_tdata, m_tlast and m_argmax stable. m_tvalid never drops without a
// transfer.
// -----------------------------------------------------------------------------
module beta_serializer #(
  parameter int A     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [A*8-1:0]             beta,
  input  logic                       beta_tvalid,
  output logic [7:0]                 m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [$clog2(A)-1:0]       m_argmax,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int IW = $clog2(A);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int W  = A * 8;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state;
  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [IW-1:0]   idx;
  logic [W-1:0]    shreg;     // elements not yet presented, next one in [7:0]
  logic [W-1:0]    head;
  logic            hs;
  logic            last_beat;
  logic            full;
  logic            pop;
  logic            push;

  assign head      = mem[rd_ptr];
  assign hs        = (state == SEND) && m_tready;
  assign last_beat = (idx == IW'(A - 1));
  assign full      = (fifo_count == CW'(DEPTH));
  // A load happens from IDLE, or on the final beat of a vector so that the
  // next vector follows with no bubble.
  assign pop       = (fifo_count != '0) && ((state == IDLE) || (hs && last_beat));
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push      = beta_tvalid && (!full || pop);
  assign m_tvalid  = (state == SEND);

  // Vector storage needs no reset: fifo_count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= beta;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (beta_tvalid && !push) overflow <= 1'b1;
    end
  end

  // Output FSM. Data and last are registered directly, so they only change
  // on a load or a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      shreg   <= '0;
      m_tdata <= '0;
      m_tlast <= 1'b0;
    end else begin
      if (pop) begin
        state   <= SEND;
        idx     <= '0;
        m_tdata <= head[7:0];
        shreg   <= head >> 8;
        m_tlast <= 1'b0;
      end else if (hs && last_beat) begin
        state   <= IDLE;
        m_tlast <= 1'b0;
      end else if (hs) begin
        idx     <= idx + IW'(1);
        m_tdata <= shreg[7:0];
        shreg   <= shreg >> 8;
        m_tlast <= (idx == IW'(A - 2));
      end
    end
  end

`ifdef BETA_ARGMAX_EN
  logic [IW-1:0] argmax_q;
  logic [IW-1:0] head_argmax;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    logic signed [7:0] best;
    best        = head[7:0];
    head_argmax = '0;
    for (int k = 1; k < A; k++) begin
      if ($signed(head[k*8 +: 8]) > best) begin
        best        = head[k*8 +: 8];
        head_argmax = IW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   argmax_q <= '0;
    else if (pop) argmax_q <= head_argmax;
  end

  assign m_argmax = argmax_q;
`else
  assign m_argmax = '0;
`endif

endmodule

// File: tb/tb_beta_serializer.sv
module tb_beta_serializer;

  localparam int A     = 2;
  localparam int DEPTH = 4;
  localparam int W     = A * 8;
  localparam int IW    = $clog2(A);
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic [W-1:0]      beta;
  logic              beta_tvalid;
  logic [7:0]        m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [IW-1:0]     m_argmax;
  logic [CW-1:0]     fifo_count;
  logic              overflow;

  always #5 clk = ~clk;

  beta_serializer #(.A(A), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .beta        (beta),
    .beta_tvalid (beta_tvalid),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_argmax    (m_argmax),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  // ---------------- counters ----------------
  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Transaction-level view: a queue of stored vectors, the vector being sent
  // and which of its elements is on the output.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;
  int           cur_idx;
  bit           e_valid;
  bit           e_ovf;

  function automatic int ref_argmax(input logic [W-1:0] v);
    int best_i = 0;
    int best_v = $signed(v[7:0]);
    for (int k = 1; k < A; k++) begin
      int x = $signed(v[k*8 +: 8]);
      if (x > best_v) begin
        best_v = x;
        best_i = k;
      end
    end
`ifdef BETA_ARGMAX_EN
    return best_i;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cur     = '0;
    cur_idx = 0;
    e_valid = 0;
    e_ovf   = 0;
  endtask

  // Apply one clock edge to the model using the inputs that were sampled.
  task automatic model_edge();
    bit hs, last, pop, push;
    hs   = e_valid && m_tready;
    last = (cur_idx == A - 1);
    pop  = (exp_q.size() > 0) && (!e_valid || (hs && last));
    push = beta_tvalid && ((exp_q.size() < DEPTH) || pop);
    if (beta_tvalid && !push) e_ovf = 1;
    if (pop) begin
      cur     = exp_q.pop_front();
      cur_idx = 0;
      e_valid = 1;
    end else if (hs && last) begin
      e_valid = 0;
    end else if (hs) begin
      cur_idx++;
    end
    if (push) exp_q.push_back(beta);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("m_tvalid", 32'(m_tvalid), 32'(e_valid));
    chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    if (e_valid) begin
      chk("m_tdata", 32'(m_tdata), 32'(cur[cur_idx*8 +: 8]));
      chk("m_tlast", 32'(m_tlast), 32'(cur_idx == A - 1));
      chk("m_argmax", 32'(m_argmax), 32'(ref_argmax(cur)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit tv, input logic [W-1:0] v, input bit rdy);
    @(negedge clk);
    beta_tvalid = tv;
    beta        = v;
    m_tready    = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    beta_tvalid = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_argmax", 32'(m_argmax), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int k = 0; k < A; k++) v[k*8 +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] seq [4];
    logic [W-1:0] v;

    rst_n       = 1'b0;
    beta        = '0;
    beta_tvalid = 1'b0;
    m_tready    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // single vector, two-edge latency
    step(1, 16'h05FB, 1);
    chk("lat_idle", 32'(m_tvalid), 32'd0);
    step(0, '0, 1);
    chk("single_b0", 32'(m_tdata), 32'hFB);
    chk("single_b0_last", 32'(m_tlast), 32'd0);
    step(0, '0, 1);
    chk("single_b1", 32'(m_tdata), 32'h05);
    chk("single_b1_last", 32'(m_tlast), 32'd1);
    step(0, '0, 1);
    chk("single_done", 32'(m_tvalid), 32'd0);

    // back-to-back vectors with no bubble
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04;
    step(1, 16'h0201, 1);
    step(1, 16'h0403, 1);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", 32'(m_tvalid), 32'd1);
      chk("b2b_data", 32'(m_tdata), 32'(seq[i]));
      chk("b2b_last", 32'(m_tlast), 32'(i % 2));
      step(0, '0, 1);
    end
    chk("b2b_done", 32'(m_tvalid), 32'd0);

    // backpressure on beat 0
    step(1, 16'hBBAA, 0);
    step(0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 0);
      chk("bp_hold_valid", 32'(m_tvalid), 32'd1);
      chk("bp_hold_data", 32'(m_tdata), 32'hAA);
    end
    step(0, '0, 1);
    chk("bp_resume", 32'(m_tdata), 32'hBB);
    step(0, '0, 1);

    // overflow: six writes while stalled
    for (int i = 0; i < 6; i++) step(1, rand_vec(), 0);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 12; i++) step(0, '0, 1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();

    // full FIFO plus pop on the final handshake
    for (int i = 0; i < 5; i++) step(1, rand_vec(), 0);
    chk("full_count", 32'(fifo_count), 32'd4);
    step(0, '0, 1);
    step(1, rand_vec(), 1);
    chk("fullpop_count", 32'(fifo_count), 32'd4);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 12; i++) step(0, '0, 1);

    // reset in the middle of a vector
    step(1, 16'h2211, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    do_reset();
    v = 16'h4433;
    step(1, v, 1);
    step(0, '0, 1);
    chk("post_rst_b0", 32'(m_tdata), 32'h33);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 1) == 1), rand_vec(), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 12; i++) step(0, '0, 1);
    chk("final_idle", 32'(m_tvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
